rnd_vec_gen_multi: RTL

//  Parametrised pseudo-random vector generator for the SDRAM memtest data/address paths.

---
 rtl/rnd_vec_gen_multi_if.sv | 29 ++
 rtl/rnd_vec_gen_multi.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rnd_vec_gen_multi_if.sv
// Control/data bundle for the pseudo-random vector generator.
// The sequencer side (master) drives the strobes and reads back the
// generator state; the generator side (slave) does the reverse.
interface rnd_vec_gen_multi_if #(
  parameter int OUT_SIZE = 16,
  parameter int SLOT_W   = 2,
  parameter int SKIP_W   = 8
);
  logic                init;
  logic [OUT_SIZE-1:0] seed;
  logic                save;
  logic                restore;
  logic [SLOT_W-1:0]   slot;
  logic                next;
  logic                skip_start;
  logic [SKIP_W-1:0]   skip_count;
  logic                busy;
  logic [OUT_SIZE-1:0] out;

  modport master (
    output init, seed, save, restore, slot, next, skip_start, skip_count,
    input  busy, out
  );

  modport slave (
    input  init, seed, save, restore, slot, next, skip_start, skip_count,
    output busy, out
  );
endinterface

// File: rtl/rnd_vec_gen_multi.sv
// Pseudo-random vector generator for the SDRAM memtest data/address paths.
// The step is either add-constant-then-rotate-right or a right-shifting
// Galois LFSR. The state can be seeded, saved to / restored from a small
// bank of slots, and advanced many steps by a skip-ahead engine that walks
// one step per cycle while busy is high.
module rnd_vec_gen_multi #(
  parameter int                  OUT_SIZE  = 16,
  parameter int                  MODE      = 0,
  parameter int                  ADD_CONST = 36653,
  parameter logic [OUT_SIZE-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [OUT_SIZE-1:0] RESET_VAL = '0,
  parameter int                  NSLOTS    = 4,
  parameter int                  SLOT_W    = 2,
  parameter int                  SKIP_W    = 8
) (
  input logic                clk,
  input logic                rst_n,
  rnd_vec_gen_multi_if.slave bus
);

  localparam logic [OUT_SIZE-1:0] ADD_K = OUT_SIZE'(ADD_CONST);
  localparam logic [OUT_SIZE-1:0] ONE   = OUT_SIZE'(1);
  // An all-zero LFSR state never leaves zero, so in LFSR mode any zero load
  // (including the reset value) is replaced by one.
  localparam logic [OUT_SIZE-1:0] RESET_LOAD =
    (MODE == 1 && RESET_VAL == '0) ? ONE : RESET_VAL;

  typedef enum logic {
    IDLE = 1'b0,
    SKIP = 1'b1
  } fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [OUT_SIZE-1:0] state_q, state_d;
  logic [SKIP_W-1:0]   rem_q, rem_d;
  logic [OUT_SIZE-1:0] slots_q [NSLOTS];
  logic                save_en;
  logic                slot_ok;
  logic [OUT_SIZE-1:0] slot_val;

  // One generator step in the selected mode.
  function automatic logic [OUT_SIZE-1:0] step_fn(input logic [OUT_SIZE-1:0] s);
    logic [OUT_SIZE-1:0] t;
    t = s + ADD_K;
    if (MODE == 0) begin
      return {t[0], t[OUT_SIZE-1:1]};
    end
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // Value actually stored when loading the state from seed or a slot.
  function automatic logic [OUT_SIZE-1:0] load_fn(input logic [OUT_SIZE-1:0] v);
    if (MODE == 1 && v == '0) begin
      return ONE;
    end
    return v;
  endfunction

  // Decode the slot index: out-of-range indices make save/restore no-ops.
  always_comb begin
    slot_ok  = 1'b0;
    slot_val = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (bus.slot == SLOT_W'(i)) begin
        slot_ok  = 1'b1;
        slot_val = slots_q[i];
      end
    end
  end

  // Next-state logic: init beats everything, a running skip swallows other
  // strobes, and in IDLE restore beats skip_start beats next.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rem_d   = rem_q;
    save_en = 1'b0;
    if (bus.init) begin
      state_d = load_fn(bus.seed);
      rem_d   = '0;
      fsm_d   = IDLE;
    end else begin
      case (fsm_q)
        SKIP: begin
          state_d = step_fn(state_q);
          rem_d   = rem_q - SKIP_W'(1);
          if (rem_q == SKIP_W'(1)) begin
            fsm_d = IDLE;
          end
        end
        IDLE: begin
          if (bus.restore) begin
            if (slot_ok) begin
              state_d = load_fn(slot_val);
            end
          end else begin
            save_en = bus.save && slot_ok;
            if (bus.skip_start) begin
              if (bus.skip_count != '0) begin
                rem_d = bus.skip_count;
                fsm_d = SKIP;
              end
            end else if (bus.next) begin
              state_d = step_fn(state_q);
            end
          end
        end
        default: begin
          fsm_d = IDLE;
        end
      endcase
    end
  end

  // State, remaining-step counter and FSM registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= RESET_LOAD;
      rem_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Save bank: captures the pre-step state of the current cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOTS; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSLOTS; i++) begin
        if (save_en && bus.slot == SLOT_W'(i)) begin
          slots_q[i] <= state_q;
        end
      end
    end
  end

  assign bus.busy = (fsm_q == SKIP);
  assign bus.out  = state_q;

endmodule
